// File: rtl/serial_adder_nbit_if.sv
// Operand/result handshake bundle for serial_adder_nbit.
//   master: producer/consumer side (drives operands, accepts results)
//   slave : the adder itself
// Signals:
//   in_valid/in_ready   operand handshake
//   sub, A, B, Cin      operation select and operands
//   out_valid/out_ready result handshake
//   S, Cout             result and raw carry out of the MSB
interface serial_adder_nbit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;

  modport master (
    output in_valid, sub, A, B, Cin, out_ready,
    input  in_ready, out_valid, S, Cout
  );

  modport slave (
    input  in_valid, sub, A, B, Cin, out_ready,
    output in_ready, out_valid, S, Cout
  );
endinterface

// File: rtl/serial_adder_nbit.sv
// Multi-cycle adder/subtractor: one DIGIT-bit ripple slice is reused for WIDTH/DIGIT cycles,
// with the slice carry registered between cycles.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   io    serial_adder_nbit_if.slave: operand handshake (in_valid/in_ready, sub, A, B, Cin)
//         and result handshake (out_valid/out_ready, S, Cout)
//   busy  high while an operation is being computed
// Subtraction is A + ~B + ~borrow, so Cout=1 means "no borrow" when sub=1.
module serial_adder_nbit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  serial_adder_nbit_if.slave io,
  output logic              busy
);

  localparam int unsigned NSTEP = WIDTH / DIGIT;
  localparam int unsigned CntW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder_nbit: WIDTH must be a nonzero multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  step_q, step_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  logic                   accept;
  logic [DIGIT:0]         slice;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_shift;

  // A finished result can be handed off and a new operand taken on the same edge.
  assign io.in_ready = (state_q == StIdle) || ((state_q == StDone) && io.out_ready);
  assign accept      = io.in_valid && io.in_ready;

  assign io.out_valid = out_valid_q;
  assign io.S         = s_q;
  assign io.Cout      = cout_q;
  assign busy         = (state_q == StRun);

  always_comb begin
    slice = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // New digit enters at the top; after NSTEP steps the LSB digit has reached bit 0.
    res_cat   = {slice[DIGIT-1:0], res_q};
    res_shift = WIDTH'(res_cat >> DIGIT);
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    res_d       = res_q;
    step_d      = step_q;
    s_d         = s_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: ;
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = slice[DIGIT];
        res_d   = res_shift;
        step_d  = step_q + CntW'(1);
        if (step_q == CntW'(NSTEP - 1)) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          s_d         = res_shift;
          cout_d      = slice[DIGIT];
        end
      end
      StDone: begin
        if (io.out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      a_d         = io.A;
      b_d         = io.B ^ {WIDTH{io.sub}};
      carry_d     = io.Cin ^ io.sub;
      res_d       = '0;
      step_d      = '0;
      state_d     = StRun;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      res_q       <= '0;
      step_q      <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      res_q       <= res_d;
      step_q      <= step_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Self-checking bench for serial_adder_nbit: an 8-bit/1-digit instance and a 16-bit/4-digit
// instance, checked against a plain-arithmetic reference model.
module tb_serial_adder_nbit;

  logic clk = 1'b0;
  logic rst;
  logic busy8;
  logic busy16;
  int   checks = 0;
  int   errors = 0;

  serial_adder_nbit_if #(.WIDTH(8))  if8 ();
  serial_adder_nbit_if #(.WIDTH(16)) if16 ();

  serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .io   (if8),
    .busy (busy8)
  );

  serial_adder_nbit #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk  (clk),
    .rst  (rst),
    .io   (if16),
    .busy (busy16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: modular add, or subtract with Cout = "no borrow".
  task automatic model(input int w, input longint unsigned a, input longint unsigned b,
                       input bit cin, input bit sub, output logic [31:0] s, output logic c);
    longint unsigned mask;
    longint unsigned r;
    mask = (64'd1 << w) - 64'd1;
    if (!sub) begin
      r = a + b + 64'(cin);
      s = 32'(r & mask);
      c = r[w];
    end else begin
      r = a - b - 64'(cin);
      s = 32'(r & mask);
      c = (a >= b + 64'(cin));
    end
  endtask

  // Wait for in_ready, issue one operation, wait for the result and check it. Leaves DONE.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic s,
                     input string tag);
    logic [31:0] es;
    logic        ec;
    int          lat = 0;
    int          bc = 0;
    int          w = 0;
    model(8, 64'(a), 64'(b), cin, s, es, ec);
    while (!if8.in_ready && w < 20) begin
      tick();
      w++;
    end
    chk({tag, ":in_ready"}, 32'(if8.in_ready), 32'd1);
    if8.A = a; if8.B = b; if8.Cin = cin; if8.sub = s; if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    while (!if8.out_valid && lat < 40) begin
      if (busy8) bc++;
      tick();
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'd8);
    chk({tag, ":busy_cycles"}, 32'(bc), 32'd8);
    chk({tag, ":S"}, 32'(if8.S), es);
    chk({tag, ":Cout"}, 32'(if8.Cout), 32'(ec));
  endtask

  task automatic retire8(input string tag);
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
    chk({tag, ":retired_valid"}, 32'(if8.out_valid), 32'd0);
    chk({tag, ":retired_ready"}, 32'(if8.in_ready), 32'd1);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic s, input string tag);
    logic [31:0] es;
    logic        ec;
    int          lat = 0;
    int          w = 0;
    model(16, 64'(a), 64'(b), cin, s, es, ec);
    while (!if16.in_ready && w < 20) begin
      tick();
      w++;
    end
    chk({tag, ":in_ready"}, 32'(if16.in_ready), 32'd1);
    if16.A = a; if16.B = b; if16.Cin = cin; if16.sub = s; if16.in_valid = 1'b1;
    tick();
    if16.in_valid = 1'b0;
    while (!if16.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'd4);
    chk({tag, ":S"}, 32'(if16.S), es);
    chk({tag, ":Cout"}, 32'(if16.Cout), 32'(ec));
    if16.out_ready = 1'b1;
    tick();
    if16.out_ready = 1'b0;
    chk({tag, ":retired_valid"}, 32'(if16.out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.A = '0; if8.B = '0;
    if8.Cin = 1'b0; if8.sub = 1'b0;
    if16.in_valid = 1'b0; if16.out_ready = 1'b0; if16.A = '0; if16.B = '0;
    if16.Cin = 1'b0; if16.sub = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset:out_valid", 32'(if8.out_valid), 32'd0);
    chk("reset:busy", 32'(busy8), 32'd0);
    chk("reset:in_ready", 32'(if8.in_ready), 32'd1);
    chk("reset:S", 32'(if8.S), 32'd0);
    chk("reset:Cout", 32'(if8.Cout), 32'd0);

    // Directed add/subtract cases.
    op8(8'h5A, 8'h3C, 1'b0, 1'b0, "add_5a_3c");  retire8("add_5a_3c");
    op8(8'hFF, 8'h01, 1'b0, 1'b0, "wrap_ff_01"); retire8("wrap_ff_01");
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, "wrap_ff_ff"); retire8("wrap_ff_ff");
    op8(8'h10, 8'h01, 1'b0, 1'b1, "sub_10_01");  retire8("sub_10_01");
    op8(8'h01, 8'h02, 1'b0, 1'b1, "sub_01_02");  retire8("sub_01_02");
    op8(8'h05, 8'h05, 1'b1, 1'b1, "sub_05_05");  retire8("sub_05_05");

    // Back-pressure: result must hold while out_ready=0 even with new operands offered.
    op8(8'h5A, 8'h3C, 1'b0, 1'b0, "bp_setup");
    for (int i = 0; i < 5; i++) begin
      if8.in_valid = 1'b1;
      if8.A = 8'($urandom);
      if8.B = 8'($urandom);
      tick();
      chk("bp:in_ready", 32'(if8.in_ready), 32'd0);
      chk("bp:out_valid", 32'(if8.out_valid), 32'd1);
      chk("bp:S", 32'(if8.S), 32'h96);
      chk("bp:Cout", 32'(if8.Cout), 32'd0);
      chk("bp:busy", 32'(busy8), 32'd0);
    end
    // Handoff and new accept on the same edge.
    if8.A = 8'h01; if8.B = 8'h02; if8.Cin = 1'b0; if8.sub = 1'b0; if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
    if8.in_valid = 1'b0;
    chk("b2b:out_valid", 32'(if8.out_valid), 32'd0);
    chk("b2b:busy", 32'(busy8), 32'd1);
    lat = 0;
    while (!if8.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("b2b:latency", 32'(lat), 32'd8);
    chk("b2b:S", 32'(if8.S), 32'h03);
    chk("b2b:Cout", 32'(if8.Cout), 32'd0);
    retire8("b2b");

    // Reset at step 3 of a RUN discards the operation.
    if8.A = 8'h77; if8.B = 8'h11; if8.Cin = 1'b0; if8.sub = 1'b0; if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst:out_valid", 32'(if8.out_valid), 32'd0);
    chk("midrst:S", 32'(if8.S), 32'd0);
    chk("midrst:Cout", 32'(if8.Cout), 32'd0);
    chk("midrst:busy", 32'(busy8), 32'd0);
    chk("midrst:in_ready", 32'(if8.in_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("midrst:no_result", 32'(if8.out_valid), 32'd0);
    end
    op8(8'h22, 8'h11, 1'b0, 1'b0, "after_rst"); retire8("after_rst");

    // Randomised 8-bit operations.
    for (int i = 0; i < 20; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "rand8");
      retire8("rand8");
    end

    // 16-bit, 4 bits per step.
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, "w16_wrap");
    op16(16'h1234, 16'h4321, 1'b1, 1'b1, "w16_sub");
    for (int i = 0; i < 10; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand16");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_nbit.md
Name: serial_adder_nbit

Overview:
- Multi-cycle, parametrised successor to the 1-bit full adder (ports A, B, Cin, S, Cout).
- Adds or subtracts two WIDTH-bit operands over WIDTH/DIGIT cycles, reusing one DIGIT-bit ripple slice with a registered carry between cycles.
- Operands enter through a valid/ready input handshake and results leave through a valid/ready output handshake.
- Used wherever area matters more than latency in mapped arithmetic benchmarks.

Parameters:
- WIDTH, 8, operand and result width in bits.
- DIGIT, 1, bits processed per cycle. WIDTH % DIGIT must be 0; elaboration fails otherwise.
- NSTEP, WIDTH/DIGIT, derived and not overridable; number of add cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept an operand bundle.
- sub  input  1  0 computes A+B+Cin; 1 computes A-B-Cin.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in when sub=0; borrow-in when sub=1.
- out_valid  output  1  S/Cout valid.
- out_ready  input  1  consumer accepts the result.
- S  output  WIDTH  sum or difference.
- Cout  output  1  raw carry out of the MSB (for sub=1, 1 means no borrow).
- busy  output  1  high while in RUN.

Behaviour:
- Reset: rst=1 at an edge forces state=IDLE, out_valid=0, S=0, Cout=0, busy=0, step counter=0, internal operand/carry registers=0.
  - Reset applies in any state, including mid-RUN and DONE. The in-flight operation is discarded and no result is emitted.
  - in_ready=1 in the cycle after reset.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) or (state==DONE and out_ready). Combinational; no dependence on in_valid.
- Accept occurs when in_valid and in_ready are both high at an edge. On accept:
  - A is latched.
  - B is latched as B XOR {WIDTH{sub}}.
  - carry is latched as Cin XOR sub.
  - step counter=0, state becomes RUN, out_valid drops to 0.
  - Inputs are ignored at every edge other than an accept edge.
- RUN, at each edge:
  - Add the low DIGIT bits of the A and B shift registers plus carry.
  - Shift the DIGIT sum bits into the top of the result register and shift both operand registers right by DIGIT.
  - The carry register takes the slice carry-out.
  - step counter increments.
  - On the edge completing step NSTEP-1: state becomes DONE, out_valid=1, S=full result, Cout=final carry.
- Latency: out_valid is high exactly NSTEP cycles after the accept edge.
- DONE:
  - S, Cout and out_valid are held stable while out_ready=0 (back-pressure).
  - Edge with out_ready=1 and no accept: state becomes IDLE, out_valid=0. S/Cout keep their last values, but consumers must ignore them while out_valid=0.
  - Edge with out_ready=1 and in_valid=1: result handoff and new accept happen on the same edge, so the next state is RUN. Back-to-back throughput is one result per NSTEP+1 cycles.
- busy = (state==RUN).
- Width rules: all arithmetic is modulo 2^WIDTH. Cout is the true carry out of bit WIDTH-1. No overflow flag.
- S changes only on the DONE-entry edge or at reset. The result register is internal during RUN.

Test Plan:
- WIDTH=8, DIGIT=1; A=0x5A, B=0x3C, Cin=0, sub=0 -> S=0x96, Cout=0. out_valid rises exactly 8 cycles after accept; busy high for those 8 cycles.
- Carry wrap: A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1. Then A=0xFF, B=0xFF, Cin=1 -> S=0xFF, Cout=1.
- Subtract:
  - A=0x10, B=0x01, Cin=0, sub=1 -> S=0x0F, Cout=1.
  - A=0x01, B=0x02, sub=1 -> S=0xFF, Cout=0.
  - A=0x05, B=0x05, Cin=1, sub=1 -> S=0xFF, Cout=0.
- Back-pressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing A/B -> S/Cout constant, in_ready=0, no accept.
  - Then raise out_ready=1 with in_valid=1 (A=0x01, B=0x02) -> handoff and accept on the same edge; next result S=0x03 arrives 8 cycles later.
- Reset mid-operation: assert rst for one edge at step 3 of a RUN -> next cycle out_valid=0, S=0, Cout=0, busy=0, in_ready=1. A following 0x22+0x11 op yields S=0x33, Cout=0 with normal latency.
- WIDTH=16, DIGIT=4; 0xFFFF+0x0001, Cin=0 -> S=0x0000, Cout=1, out_valid 4 cycles after accept. WIDTH=10, DIGIT=4 must fail elaboration.
